// File: rtl/cla_arb_pkg.sv
// Shared types and constants for the round-robin CLA arbiter.
package cla_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CLA_W       = 64;
  localparam int NUM_REQ_DEF = 4;

endpackage

// File: rtl/cla_rr_arbiter_cla64.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups with a group-carry chain.
module cla_64 (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic        cin_i,
  output logic [63:0] sum_o,
  output logic        cout_o
);

  always_comb begin
    logic [63:0] g;
    logic [63:0] p;
    logic [63:0] c;
    logic [16:0] gc;
    g     = a_i & b_i;
    p     = a_i ^ b_i;
    c     = '0;
    gc    = '0;
    gc[0] = cin_i;
    for (int k = 0; k < 16; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | ((&p[4*k +: 2]) & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | ((&p[4*k+1 +: 2]) & g[4*k])
               | ((&p[4*k +: 3]) & gc[k]);
      gc[k+1]  = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | ((&p[4*k+2 +: 2]) & g[4*k+1])
               | ((&p[4*k+1 +: 3]) & g[4*k]) | ((&p[4*k +: 4]) & gc[k]);
    end
    sum_o  = p ^ c;
    cout_o = gc[16];
  end

endmodule

// File: rtl/cla_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first valid index after last_grant, wrapping.
module rr_pick
  import cla_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic               any_o,
  output logic [ID_W-1:0]    grant_o
);

  logic [NUM_REQ-1:0]   mask;
  logic [2*NUM_REQ-1:0] dbl;
  logic                 found;

  // Low half holds only indices above last_grant; the high half is the wrapped copy.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (ID_W'(i) > last_grant_i);
    end
    dbl     = {req_i, req_i & mask};
    any_o   = |req_i;
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      if (!found && dbl[i]) begin
        found   = 1'b1;
        grant_o = ID_W'(i % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/cla_rr_arbiter.sv
// Round-robin arbiter sharing one CLA_64 between NUM_REQ requesters.
// Three-cycle issue: IDLE (grant) -> EXEC (add) -> RESP (hold until consumed).
module cla_rr_arbiter
  import cla_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*CLA_W-1:0] req_a_i,
  input  logic [NUM_REQ*CLA_W-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]       req_cin_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [CLA_W-1:0]         rsp_result_o,
  output logic                     rsp_cout_o,
  output logic                     busy_o
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    last_grant_q;
  logic [CLA_W-1:0]   op_a_q, op_b_q;
  logic               op_cin_q;
  logic [ID_W-1:0]    op_id_q;
  logic [CLA_W-1:0]   rsp_result_q;
  logic               rsp_cout_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic               pick_any;
  logic [ID_W-1:0]    pick_id;
  logic [CLA_W-1:0]   sum;
  logic               cout;
  logic               issue;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req_i        (req_valid_i),
    .last_grant_i (last_grant_q),
    .any_o        (pick_any),
    .grant_o      (pick_id)
  );

  cla_64 u_cla (
    .a_i    (op_a_q),
    .b_i    (op_b_q),
    .cin_i  (op_cin_q),
    .sum_o  (sum),
    .cout_o (cout)
  );

  assign issue = (state_q == IDLE) && pick_any;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by reset so a held request is not acknowledged while in reset.
  always_comb begin
    req_ready_o = '0;
    if (issue && rst_ni) req_ready_o[pick_id] = 1'b1;
    rsp_valid_o = (state_q == RESP);
    busy_o      = (state_q != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_cin_q     <= 1'b0;
      op_id_q      <= '0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      if (issue) begin
        op_a_q       <= req_a_i[pick_id*CLA_W +: CLA_W];
        op_b_q       <= req_b_i[pick_id*CLA_W +: CLA_W];
        op_cin_q     <= req_cin_i[pick_id];
        op_id_q      <= pick_id;
        last_grant_q <= pick_id;
      end
      if (state_q == EXEC) begin
        rsp_result_q <= sum;
        rsp_cout_q   <= cout;
        rsp_id_q     <= op_id_q;
      end
    end
  end

  assign rsp_result_o = rsp_result_q;
  assign rsp_cout_o   = rsp_cout_q;
  assign rsp_id_o     = rsp_id_q;

endmodule

// File: tb/tb_cla_rr_arbiter.sv
// Directed and randomized checks of cla_rr_arbiter with NUM_REQ=4.
module tb_cla_rr_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic [3:0]   req_cin;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_result;
  logic         rsp_cout;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  cla_rr_arbiter #(.NUM_REQ(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_cin_i    (req_cin),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result),
    .rsp_cout_o   (rsp_cout),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic [63:0] a, input logic [63:0] b, input logic c);
    req_a[64*r +: 64] = a;
    req_b[64*r +: 64] = b;
    req_cin[r]        = c;
  endtask

  // Expects IDLE and rsp_ready=1 on entry.
  task automatic run_single(input int id, input logic [63:0] a, input logic [63:0] b,
                            input logic c, input logic [63:0] er, input logic ec);
    set_op(id, a, b, c);
    req_valid = 4'(1 << id);
    #1;
    chk("single_ready", req_ready, 64'(1 << id));
    cyc();
    req_valid = 4'b0;
    cyc();
    chk("single_rspv", rsp_valid, 1);
    chk("single_id", rsp_id, 64'(id));
    chk("single_result", rsp_result, er);
    chk("single_cout", rsp_cout, ec);
    cyc();
    chk("single_rspv_drop", rsp_valid, 0);
  endtask

  logic [63:0] exp2 [4] = '{64'd18, 64'd1022, 64'd2024, 64'd3028};
  logic [63:0] ra [4];
  logic [63:0] rb [4];
  logic [3:0]  rc;
  logic [3:0]  pend;
  int          wait_cnt [4];
  logic        outstanding;
  logic [63:0] exp_res;
  logic        exp_cout;
  logic [1:0]  exp_id;
  int          nacc, nrsp, g;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b0;
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_cout", rsp_cout, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Single requester 2: 5 + 7 + 1
    set_op(2, 64'd5, 64'd7, 1'b1);
    req_valid = 4'b0100;
    #1;
    chk("t1_ready", req_ready, 4'b0100);
    chk("t1_busy_idle", busy, 0);
    cyc();
    req_valid = 4'b0;
    chk("t1_exec_ready", req_ready, 0);
    chk("t1_exec_busy", busy, 1);
    chk("t1_exec_rspv", rsp_valid, 0);
    cyc();
    chk("t1_rspv", rsp_valid, 1);
    chk("t1_id", rsp_id, 2);
    chk("t1_result", rsp_result, 13);
    chk("t1_cout", rsp_cout, 0);
    rsp_ready = 1'b1;
    cyc();
    chk("t1_rspv_drop", rsp_valid, 0);
    chk("t1_busy_drop", busy, 0);

    // All four valid from reset: order 0,1,2,3,0,...
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) set_op(r, 64'(r*1000 + 17), 64'(r*3 + 1), r[0]);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t2_ready", req_ready, 64'(1 << (k % 4)));
      cyc();
      cyc();
      chk("t2_rspv", rsp_valid, 1);
      chk("t2_id", rsp_id, 64'(k % 4));
      chk("t2_result", rsp_result, exp2[k % 4]);
      cyc();
    end
    req_valid = 4'b0;

    // Wrap and carry propagation, requester 1 re-granted back-to-back
    run_single(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1);
    run_single(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1);
    run_single(1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0);
    run_single(1, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0101_0101_0101_0101, 1'b0,
               64'h1010_1010_1010_1010, 1'b0);
    run_single(1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'h0, 1'b1);

    // Backpressure with all requesting; last served was 1, so 2 then 3
    for (int r = 0; r < 4; r++) set_op(r, 64'(r*1000 + 17), 64'(r*3 + 1), r[0]);
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("t4_ready", req_ready, 4'b0100);
    cyc();
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk("t4_rspv", rsp_valid, 1);
      chk("t4_id", rsp_id, 2);
      chk("t4_result", rsp_result, 64'd2024);
      chk("t4_ready_hold", req_ready, 0);
      chk("t4_busy", busy, 1);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t4_rspv_release", rsp_valid, 1);
    cyc();
    chk("t4_next_ready", req_ready, 4'b1000);
    chk("t4_rspv_drop", rsp_valid, 0);
    cyc();
    cyc();
    chk("t4_next_id", rsp_id, 3);
    chk("t4_next_result", rsp_result, 64'd3028);
    cyc();
    req_valid = 4'b0;

    // Reset during EXEC
    req_valid = 4'b0010;
    #1;
    chk("t5_ready", req_ready, 4'b0010);
    cyc();
    chk("t5_exec_busy", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5e_ready", req_ready, 0);
    chk("t5e_busy", busy, 0);
    chk("t5e_rspv", rsp_valid, 0);
    chk("t5e_result", rsp_result, 0);
    chk("t5e_id", rsp_id, 0);
    chk("t5e_cout", rsp_cout, 0);
    #1;
    rst_n = 1'b1;
    req_valid = 4'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5e_no_stale", rsp_valid, 0);
    end
    req_valid = 4'hF;
    #1;
    chk("t5e_first_grant", req_ready, 4'b0001);
    cyc();
    cyc();
    rsp_ready = 1'b0;
    #1;
    chk("t5r_rspv", rsp_valid, 1);
    chk("t5r_result", rsp_result, 64'd18);
    rst_n = 1'b0;
    #1;
    chk("t5r_rspv_rst", rsp_valid, 0);
    chk("t5r_result_rst", rsp_result, 0);
    chk("t5r_busy_rst", busy, 0);
    chk("t5r_ready_rst", req_ready, 0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t5r_first_grant", req_ready, 4'b0001);
    cyc();
    cyc();
    rsp_ready = 1'b1;
    req_valid = 4'b0;
    cyc();
    cyc();

    // Randomized traffic against a scoreboard
    pend        = '0;
    rc          = '0;
    outstanding = 1'b0;
    exp_res     = '0;
    exp_cout    = 1'b0;
    exp_id      = '0;
    nacc        = 0;
    nrsp        = 0;
    for (int r = 0; r < 4; r++) wait_cnt[r] = 0;
    for (int it = 0; it < 1500; it++) begin
      for (int r = 0; r < 4; r++) begin
        if (!pend[r] && ($urandom_range(1, 0) == 1)) begin
          pend[r]     = 1'b1;
          ra[r]       = {$urandom, $urandom};
          rb[r]       = {$urandom, $urandom};
          rc[r]       = 1'($urandom_range(1, 0));
          wait_cnt[r] = 0;
          set_op(r, ra[r], rb[r], rc[r]);
        end
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(3, 0) != 0);
      #1;
      if (rsp_valid) begin
        chk("rnd_rsp_expected", outstanding, 1);
        chk("rnd_id", rsp_id, exp_id);
        chk("rnd_result", rsp_result, exp_res);
        chk("rnd_cout", rsp_cout, exp_cout);
        if (rsp_ready) begin
          outstanding = 1'b0;
          nrsp++;
        end
      end
      if (req_ready != 4'b0) begin
        chk("rnd_ready_legal",
            64'($onehot(req_ready) && ((req_ready & ~pend) == 4'b0) && !outstanding), 1);
        g = 0;
        for (int r = 3; r >= 0; r--) if (req_ready[r]) g = r;
        for (int r = 0; r < 4; r++) begin
          if (pend[r] && r != g) begin
            wait_cnt[r]++;
            chk("rnd_wait", 64'(wait_cnt[r] <= 3), 1);
          end
        end
        {exp_cout, exp_res} = {1'b0, ra[g]} + {1'b0, rb[g]} + 65'(rc[g]);
        exp_id      = 2'(g);
        outstanding = 1'b1;
        pend[g]     = 1'b0;
        nacc++;
      end
      cyc();
    end
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rsp_valid) begin
        chk("rnd_drain_id", rsp_id, exp_id);
        chk("rnd_drain_result", rsp_result, exp_res);
        outstanding = 1'b0;
        nrsp++;
      end
      cyc();
    end
    chk("rnd_all_answered", 64'(nrsp), 64'(nacc));
    chk("rnd_progress", 64'(nacc > 250), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
